// File: rtl/sram_1rw_arbiter_init.sv
// Shares one 1RW byte-masked SRAM between two requesters after clearing the array.
// Round-robin grant, one access per cycle, read data tagged to the granted requester.
module sram_1rw_arbiter_init #(
  parameter int width_p       = 64,
  parameter int els_p         = 512,
  parameter int addr_width_lp = $clog2(els_p),
  parameter int mask_width_lp = width_p >> 3
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  output logic                     init_done_o,

  input  logic                     r0_v_i,
  input  logic                     r0_w_i,
  input  logic [addr_width_lp-1:0] r0_addr_i,
  input  logic [width_p-1:0]       r0_data_i,
  input  logic [mask_width_lp-1:0] r0_mask_i,
  output logic                     r0_ready_o,
  output logic                     r0_v_o,
  output logic [width_p-1:0]       r0_data_o,

  input  logic                     r1_v_i,
  input  logic                     r1_w_i,
  input  logic [addr_width_lp-1:0] r1_addr_i,
  input  logic [width_p-1:0]       r1_data_i,
  input  logic [mask_width_lp-1:0] r1_mask_i,
  output logic                     r1_ready_o,
  output logic                     r1_v_o,
  output logic [width_p-1:0]       r1_data_o,

  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [addr_width_lp-1:0] mem_addr_o,
  output logic [width_p-1:0]       mem_data_o,
  output logic [mask_width_lp-1:0] mem_w_mask_o,
  input  logic [width_p-1:0]       mem_data_i
);

  typedef enum logic {INIT, READY} state_e;

  state_e                   state_r;
  logic [addr_width_lp-1:0] clear_cnt_r;
  logic                     last_r1_r;
  logic                     pend0_r;
  logic                     pend1_r;

  logic serving;
  logic grant0;
  logic grant1;

  // On a tie the requester that was not granted last wins; a lone request always wins.
  assign serving = (state_r == READY) && reset_n_i;
  assign grant0  = serving && r0_v_i && (!r1_v_i || last_r1_r);
  assign grant1  = serving && r1_v_i && (!r0_v_i || !last_r1_r);

  assign r0_ready_o  = grant0;
  assign r1_ready_o  = grant1;
  assign init_done_o = (state_r == READY);

  // Pending flags are gated by reset so a response in flight at reset is dropped.
  assign r0_v_o    = pend0_r && reset_n_i;
  assign r1_v_o    = pend1_r && reset_n_i;
  assign r0_data_o = mem_data_i;
  assign r1_data_o = mem_data_i;

  always_comb begin
    mem_v_o      = 1'b0;
    mem_w_o      = 1'b0;
    mem_addr_o   = clear_cnt_r;
    mem_data_o   = '0;
    mem_w_mask_o = '1;
    if (reset_n_i) begin
      if (state_r == INIT) begin
        mem_v_o = 1'b1;
        mem_w_o = 1'b1;
      end else if (grant0) begin
        mem_v_o      = 1'b1;
        mem_w_o      = r0_w_i;
        mem_addr_o   = r0_addr_i;
        mem_data_o   = r0_data_i;
        mem_w_mask_o = r0_mask_i;
      end else if (grant1) begin
        mem_v_o      = 1'b1;
        mem_w_o      = r1_w_i;
        mem_addr_o   = r1_addr_i;
        mem_data_o   = r1_data_i;
        mem_w_mask_o = r1_mask_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r     <= INIT;
      clear_cnt_r <= '0;
      last_r1_r   <= 1'b1;
      pend0_r     <= 1'b0;
      pend1_r     <= 1'b0;
    end else begin
      pend0_r <= grant0 && !r0_w_i;
      pend1_r <= grant1 && !r1_w_i;
      case (state_r)
        INIT: begin
          clear_cnt_r <= clear_cnt_r + 1'b1;
          if (clear_cnt_r == addr_width_lp'(els_p - 1))
            state_r <= READY;
        end
        READY: begin
          if (grant0)
            last_r1_r <= 1'b0;
          else if (grant1)
            last_r1_r <= 1'b1;
        end
        default: state_r <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_1rw_arbiter_init.sv
// Directed bench for sram_1rw_arbiter_init with a behavioural byte-masked SRAM model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_sram_1rw_arbiter_init;

  localparam int W  = 64;
  localparam int N  = 512;
  localparam int AW = 9;
  localparam int MW = 8;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          init_done_o;
  logic          r0_v_i, r0_w_i, r0_ready_o, r0_v_o;
  logic [AW-1:0] r0_addr_i;
  logic [W-1:0]  r0_data_i, r0_data_o;
  logic [MW-1:0] r0_mask_i;
  logic          r1_v_i, r1_w_i, r1_ready_o, r1_v_o;
  logic [AW-1:0] r1_addr_i;
  logic [W-1:0]  r1_data_i, r1_data_o;
  logic [MW-1:0] r1_mask_i;
  logic          mem_v_o, mem_w_o;
  logic [AW-1:0] mem_addr_o;
  logic [W-1:0]  mem_data_o, mem_data_i;
  logic [MW-1:0] mem_w_mask_o;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] mem_model [N];

  always #5 clk_i = ~clk_i;

  sram_1rw_arbiter_init dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .init_done_o(init_done_o),
    .r0_v_i(r0_v_i), .r0_w_i(r0_w_i), .r0_addr_i(r0_addr_i), .r0_data_i(r0_data_i),
    .r0_mask_i(r0_mask_i), .r0_ready_o(r0_ready_o), .r0_v_o(r0_v_o), .r0_data_o(r0_data_o),
    .r1_v_i(r1_v_i), .r1_w_i(r1_w_i), .r1_addr_i(r1_addr_i), .r1_data_i(r1_data_i),
    .r1_mask_i(r1_mask_i), .r1_ready_o(r1_ready_o), .r1_v_o(r1_v_o), .r1_data_o(r1_data_o),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_w_mask_o(mem_w_mask_o), .mem_data_i(mem_data_i)
  );

  // The hard macro: byte-masked write, registered read data one cycle after a read.
  always @(posedge clk_i) begin
    if (mem_v_o) begin
      if (mem_w_o) begin
        for (int b = 0; b < MW; b++)
          if (mem_w_mask_o[b]) mem_model[mem_addr_o][b*8 +: 8] <= mem_data_o[b*8 +: 8];
      end else begin
        mem_data_i <= mem_model[mem_addr_o];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int req, input logic v, input logic w,
                               input logic [AW-1:0] addr, input logic [W-1:0] data,
                               input logic [MW-1:0] mask);
    if (req == 0) begin
      r0_v_i = v; r0_w_i = w; r0_addr_i = addr; r0_data_i = data; r0_mask_i = mask;
    end else begin
      r1_v_i = v; r1_w_i = w; r1_addr_i = addr; r1_data_i = data; r1_mask_i = mask;
    end
  endtask

  task automatic nextCycle;
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample;
    @(negedge clk_i);
  endtask

  task automatic idleBoth;
    applyStimulus(0, 1'b0, 1'b0, '0, '0, '0);
    applyStimulus(1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // Walks the clear sweep; optionally r1 raises a read of addr 3 at sweep cycle r1_at.
  task automatic runSweep(input int r1_at);
    for (int i = 0; i < N; i++) begin
      if (i == r1_at) applyStimulus(1, 1'b1, 1'b0, 9'd3, '0, '0);
      sample();
      checkOutput("sweep_ctl", {mem_v_o, mem_w_o, init_done_o, mem_addr_o, mem_w_mask_o},
                  {1'b1, 1'b1, 1'b0, AW'(i), 8'hFF});
      checkOutput("sweep_data", mem_data_o, 64'h0);
      if (r1_at >= 0 && i >= r1_at) checkOutput("r1_held_in_init", r1_ready_o, 1'b0);
      nextCycle();
    end
  endtask

  initial begin
    for (int a = 0; a < N; a++) mem_model[a] = 64'hA5A5_5A5A_DEAD_BEEF;
    reset_n_i = 1'b0;
    idleBoth();
    nextCycle();
    nextCycle();
    sample();
    checkOutput("reset_outputs", {r0_ready_o, r1_ready_o, r0_v_o, r1_v_o, mem_v_o, mem_w_o, init_done_o}, 7'b0);
    nextCycle();
    reset_n_i = 1'b1;

    runSweep(-1);
    sample();
    checkOutput("init_done_513", init_done_o, 1'b1);
    checkOutput("idle_no_access", {mem_v_o, r0_ready_o, r1_ready_o}, 3'b000);

    // Masked write then read of addr 5: upper bytes come from the cleared array.
    applyStimulus(0, 1'b1, 1'b1, 9'd5, 64'h1122334455667788, 8'h0F);
    sample();
    checkOutput("wr5_grant", {r0_ready_o, r1_ready_o, mem_v_o, mem_w_o, mem_addr_o, mem_w_mask_o},
                {1'b1, 1'b0, 1'b1, 1'b1, 9'd5, 8'h0F});
    checkOutput("wr5_data", mem_data_o, 64'h1122334455667788);
    nextCycle();
    applyStimulus(0, 1'b1, 1'b0, 9'd5, '0, '0);
    sample();
    checkOutput("rd5_grant", {r0_ready_o, mem_w_o, r0_v_o}, 3'b100);
    nextCycle();
    idleBoth();
    sample();
    checkOutput("rd5_valid", {r0_v_o, r1_v_o}, 2'b10);
    checkOutput("rd5_data", r0_data_o, 64'h0000000055667788);
    checkOutput("init_done_stays", init_done_o, 1'b1);

    // Back-to-back full-mask writes to addr 9 from r0 then r1, then r0 reads it.
    nextCycle();
    applyStimulus(0, 1'b1, 1'b1, 9'd9, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
    sample();
    checkOutput("wrA_grant", {r0_ready_o, r1_ready_o}, 2'b10);
    nextCycle();
    idleBoth();
    applyStimulus(1, 1'b1, 1'b1, 9'd9, 64'hBBBB_BBBB_BBBB_BBBB, 8'hFF);
    sample();
    checkOutput("wrB_grant", {r0_ready_o, r1_ready_o, r0_v_o, mem_data_o},
                {1'b0, 1'b1, 1'b0, 64'hBBBB_BBBB_BBBB_BBBB});
    nextCycle();
    idleBoth();
    applyStimulus(0, 1'b1, 1'b0, 9'd9, '0, '0);
    sample();
    checkOutput("rd9_grant", {r0_ready_o, r1_v_o}, 2'b10);
    nextCycle();
    idleBoth();
    sample();
    checkOutput("rd9_valid", {r0_v_o, r1_v_o}, 2'b10);
    checkOutput("rd9_data", r0_data_o, 64'hBBBB_BBBB_BBBB_BBBB);

    // Second reset: r1 asks during the sweep and must wait for READY.
    nextCycle();
    reset_n_i = 1'b0;
    nextCycle();
    reset_n_i = 1'b1;
    runSweep(100);
    sample();
    checkOutput("r1_first_ready", {init_done_o, r1_ready_o, r0_ready_o, mem_v_o, mem_w_o, mem_addr_o},
                {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 9'd3});
    nextCycle();
    idleBoth();
    sample();
    checkOutput("r1_rd_valid", {r0_v_o, r1_v_o}, 2'b01);
    checkOutput("r1_rd_data", r1_data_o, 64'h0);

    // Third reset: continuous contention alternates starting with r0.
    nextCycle();
    reset_n_i = 1'b0;
    nextCycle();
    reset_n_i = 1'b1;
    runSweep(-1);
    applyStimulus(0, 1'b1, 1'b0, 9'd1, '0, '0);
    applyStimulus(1, 1'b1, 1'b0, 9'd2, '0, '0);
    for (int k = 0; k < 7; k++) begin
      sample();
      checkOutput("rr_grant", {r0_ready_o, r1_ready_o, mem_v_o, mem_addr_o},
                  {(k % 2 == 0), (k % 2 == 1), 1'b1, (k % 2 == 0) ? 9'd1 : 9'd2});
      checkOutput("rr_resp", {r0_v_o, r1_v_o},
                  {(k > 0) && ((k - 1) % 2 == 0), (k > 0) && ((k - 1) % 2 == 1)});
      if (r0_v_o) checkOutput("rr_r0_data", r0_data_o, 64'h0);
      if (r1_v_o) checkOutput("rr_r1_data", r1_data_o, 64'h0);
      nextCycle();
    end

    // r0's read granted at k=6 is pending; a one-cycle reset must swallow it.
    reset_n_i = 1'b0;
    idleBoth();
    sample();
    checkOutput("rst_drop_resp", {r0_v_o, r1_v_o, r0_ready_o, mem_v_o, mem_w_o}, 5'b0);
    nextCycle();
    reset_n_i = 1'b1;
    sample();
    checkOutput("rst_restart0", {init_done_o, r0_v_o, mem_v_o, mem_w_o, mem_addr_o},
                {1'b0, 1'b0, 1'b1, 1'b1, 9'd0});
    nextCycle();
    sample();
    checkOutput("rst_restart1", {init_done_o, r0_v_o, mem_addr_o}, {1'b0, 1'b0, 9'd1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
